// File: rtl/four_colors_pkg.sv
// Shared constants and the checker state encoding for the four-colour solver.
// The CPU address decoder uses the same memory-map constants.
package four_colors_pkg;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    // Memory map of the shared 256x8 data memory
    localparam logic [7:0] COLOR_BASE = 8'd0;    // per-area colour array, 0 = uncoloured
    localparam logic [7:0] IDX_BASE   = 8'd23;   // neighbour-list start table
    localparam logic [7:0] NUM_AREAS  = 8'd23;   // valid areas are 0..NUM_AREAS-1
    localparam logic [7:0] LED_BASE   = 8'd159;  // LED patterns; also the last area's list end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_S = 3'd1,
        FETCH_E = 3'd2,
        NBR     = 3'd3,
        COL     = 3'd4,
        DONE    = 3'd5
    } chk_state_t;

endpackage

// File: rtl/adjacency_checker_if.sv
// Read-only request/grant port between the adjacency checker and the memory arbiter.
// Read data is combinational for the address presented in the same cycle.
interface adjacency_checker_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          mem_req;
    logic          mem_gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rdata
    );
endinterface

// File: rtl/adjacency_checker.sv
// Adjacency checker: walks an area's neighbour list in shared memory and reports
// whether any neighbour already holds the candidate colour. Read-only memory user.
module adjacency_checker
    import four_colors_pkg::*;
#(
    parameter logic [7:0] P_COLOR_BASE = COLOR_BASE,
    parameter logic [7:0] P_IDX_BASE   = IDX_BASE,
    parameter logic [7:0] P_NUM_AREAS  = NUM_AREAS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DW-1:0]              area,
    input  logic [DW-1:0]              color,
    output logic                       busy,
    output logic                       done,
    output logic                       conflict,
    output logic [DW-1:0]              conflict_area,
    output logic                       err,
    adjacency_checker_if.master        mem
);

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

    chk_state_t    state_q, state_d;
    logic [DW-1:0] area_q, area_d;
    logic [DW-1:0] color_q, color_d;
    logic [DW-1:0] nbr_q, nbr_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] end_q, end_d;
    logic          conflict_q, conflict_d;
    logic [DW-1:0] conflict_area_q, conflict_area_d;
    logic          err_q, err_d;

    logic [AW-1:0] addr_s;
    logic          req_s;
    logic [AW-1:0] rdata_a_s;

    // Read data viewed as an address (pointer and list-end values)
    assign rdata_a_s = AW'(mem.mem_rdata);

    // Address mux and request decode from the current state
    always_comb begin
        addr_s = {AW{1'b0}};
        req_s  = 1'b0;
        case (state_q)
            FETCH_S: begin
                addr_s = P_IDX_BASE + AW'(area_q);
                req_s  = 1'b1;
            end
            FETCH_E: begin
                addr_s = P_IDX_BASE + AW'(area_q) + ADDR_ONE;
                req_s  = 1'b1;
            end
            NBR: begin
                addr_s = ptr_q;
                req_s  = 1'b1;
            end
            COL: begin
                addr_s = P_COLOR_BASE + AW'(nbr_q);
                req_s  = 1'b1;
            end
            default: begin
                addr_s = {AW{1'b0}};
                req_s  = 1'b0;
            end
        endcase
    end

    // Next-state and register-update logic; a memory state without grant holds everything
    always_comb begin
        state_d         = state_q;
        area_d          = area_q;
        color_d         = color_q;
        nbr_d           = nbr_q;
        ptr_d           = ptr_q;
        end_d           = end_q;
        conflict_d      = conflict_q;
        conflict_area_d = conflict_area_q;
        err_d           = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    area_d          = area;
                    color_d         = color;
                    conflict_d      = 1'b0;
                    conflict_area_d = DATA_ZERO;
                    err_d           = 1'b0;
                    if (area >= P_NUM_AREAS) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = FETCH_S;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH_S: begin
                if (mem.mem_gnt) begin
                    ptr_d   = rdata_a_s;
                    state_d = FETCH_E;
                end else begin
                    state_d = FETCH_S;
                end
            end
            FETCH_E: begin
                if (mem.mem_gnt) begin
                    end_d = rdata_a_s;
                    if (rdata_a_s < ptr_q) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (rdata_a_s == ptr_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = NBR;
                    end
                end else begin
                    state_d = FETCH_E;
                end
            end
            NBR: begin
                if (mem.mem_gnt) begin
                    nbr_d   = mem.mem_rdata;
                    state_d = COL;
                end else begin
                    state_d = NBR;
                end
            end
            COL: begin
                if (mem.mem_gnt) begin
                    if ((mem.mem_rdata == color_q) && (color_q != DATA_ZERO)) begin
                        conflict_d      = 1'b1;
                        conflict_area_d = nbr_q;
                        state_d         = DONE;
                    end else begin
                        ptr_d = ptr_q + ADDR_ONE;
                        if ((ptr_q + ADDR_ONE) == end_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = NBR;
                        end
                    end
                end else begin
                    state_d = COL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            area_q          <= DATA_ZERO;
            color_q         <= DATA_ZERO;
            nbr_q           <= DATA_ZERO;
            ptr_q           <= {AW{1'b0}};
            end_q           <= {AW{1'b0}};
            conflict_q      <= 1'b0;
            conflict_area_q <= DATA_ZERO;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            area_q          <= area_d;
            color_q         <= color_d;
            nbr_q           <= nbr_d;
            ptr_q           <= ptr_d;
            end_q           <= end_d;
            conflict_q      <= conflict_d;
            conflict_area_q <= conflict_area_d;
            err_q           <= err_d;
        end
    end

    // Outputs decode directly from flops; mem_addr is a mux of flopped values
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign conflict      = conflict_q;
    assign conflict_area = conflict_area_q;
    assign err           = err_q;
    assign mem.mem_req   = req_s;
    assign mem.mem_addr  = addr_s;

endmodule

// File: tb/tb_adjacency_checker.sv
// Directed bench for adjacency_checker with a behavioural 256x8 memory.
module tb_adjacency_checker;
    import four_colors_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] area = 8'd0;
    logic [7:0] color = 8'd0;
    logic       busy, done, conflict, err;
    logic [7:0] conflict_area;
    logic       gnt = 1'b1;
    logic [7:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    adjacency_checker_if bus ();

    assign bus.mem_gnt   = gnt;
    assign bus.mem_rdata = mem[bus.mem_addr];

    adjacency_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .area          (area),
        .color         (color),
        .busy          (busy),
        .done          (done),
        .conflict      (conflict),
        .conflict_area (conflict_area),
        .err           (err),
        .mem           (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reset image: all colours 0; area 0 -> {1,2,4,5,6}; area 22 -> {21,6,17} ending at LED base
    task automatic load_image();
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mem[23] = 8'd47;
        for (int a = 1; a <= 21; a++) mem[23 + a] = 8'(52 + 5 * (a - 1));
        mem[45] = 8'd156;
        mem[46] = 8'd159;
        mem[47] = 8'd1; mem[48] = 8'd2; mem[49] = 8'd4; mem[50] = 8'd5; mem[51] = 8'd6;
        for (int i = 52; i < 156; i++) mem[i] = 8'(i % 23);
        mem[156] = 8'd21; mem[157] = 8'd6; mem[158] = 8'd17;
    endtask

    task automatic run_check(input string tag, input logic [7:0] a, input logic [7:0] c,
                             input logic exp_conf, input logic [7:0] exp_carea,
                             input logic exp_err, input int exp_cycle,
                             input int stall_start, input int stall_len,
                             input int poke_cycle, input logic exp_req);
        int   cycle;
        logic busy_ok, req_seen, addr_held;
        logic [7:0] held_addr;
        area = a; color = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycle = 1; busy_ok = 1'b1; req_seen = 1'b0; addr_held = 1'b1; held_addr = 8'd0;
        while (!done && cycle < 80) begin
            if (!busy) busy_ok = 1'b0;
            if (bus.mem_req) req_seen = 1'b1;
            if (stall_len > 0 && cycle == stall_start) held_addr = bus.mem_addr;
            if (stall_len > 0 && cycle >= stall_start && cycle <= stall_start + stall_len
                && bus.mem_addr !== held_addr) addr_held = 1'b0;
            gnt = !(stall_len > 0 && cycle >= stall_start && cycle < stall_start + stall_len);
            start = (cycle == poke_cycle);
            area = (cycle == poke_cycle) ? 8'd23 : a;
            @(posedge clk); #1;
            cycle++;
        end
        gnt = 1'b1; start = 1'b0;
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_cycle"}, cycle, exp_cycle);
        check_eq({tag, "_busy"}, {busy_ok, busy}, 2'b11);
        check_eq({tag, "_req_in_done"}, bus.mem_req, 1'b0);
        check_eq({tag, "_req_seen"}, req_seen, exp_req);
        check_eq({tag, "_conflict"}, conflict, exp_conf);
        check_eq({tag, "_carea"}, conflict_area, exp_carea);
        check_eq({tag, "_err"}, err, exp_err);
        if (stall_len > 0) check_eq({tag, "_addr_held"}, addr_held, 1'b1);
        @(posedge clk); #1;
        check_eq({tag, "_after"}, {done, busy, bus.mem_req}, 3'b000);
        check_eq({tag, "_hold"}, {conflict, conflict_area, err}, {exp_conf, exp_carea, exp_err});
    endtask

    initial begin
        load_image();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", {busy, done, conflict, conflict_area, err, bus.mem_req, bus.mem_addr},
                 {1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        // area 0, no conflict, K=5
        run_check("area0_free", 8'd0, 8'd3, 1'b0, 8'd0, 1'b0, 13, 0, 0, 0, 1'b1);
        // neighbour 2 coloured 3: early exit on second neighbour
        mem[2] = 8'd3;
        run_check("area0_conf", 8'd0, 8'd3, 1'b1, 8'd2, 1'b0, 7, 0, 0, 0, 1'b1);
        load_image();
        // last area: list 156..158 ends at LED base
        mem[6] = 8'd1;
        run_check("area22", 8'd22, 8'd1, 1'b1, 8'd6, 1'b0, 7, 0, 0, 0, 1'b1);
        load_image();
        // out-of-range areas
        run_check("area23", 8'd23, 8'd1, 1'b0, 8'd0, 1'b1, 1, 0, 0, 0, 1'b0);
        run_check("area255", 8'd255, 8'd2, 1'b0, 8'd0, 1'b1, 1, 0, 0, 0, 1'b0);
        // four-cycle grant drop at the first NBR
        run_check("stall", 8'd0, 8'd3, 1'b0, 8'd0, 1'b0, 17, 3, 4, 0, 1'b1);
        // start pulsed mid-scan with an illegal area must be ignored
        mem[2] = 8'd3;
        run_check("busy_start", 8'd0, 8'd3, 1'b1, 8'd2, 1'b0, 7, 0, 0, 5, 1'b1);
        load_image();
        // colour 0 matches every uncoloured neighbour's value but never conflicts
        run_check("color0", 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 13, 0, 0, 0, 1'b1);
        // empty list and inverted list
        mem[27] = 8'd62;
        run_check("empty", 8'd3, 8'd1, 1'b0, 8'd0, 1'b0, 3, 0, 0, 0, 1'b1);
        mem[27] = 8'd60;
        run_check("inverted", 8'd3, 8'd1, 1'b0, 8'd0, 1'b1, 3, 0, 0, 0, 1'b1);
        load_image();

        // reset asserted in COL of the first neighbour
        area = 8'd0; color = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("mid_col_addr", {bus.mem_req, bus.mem_addr}, {1'b1, 8'd1});
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_outs", {busy, done, conflict, conflict_area, err, bus.mem_req, bus.mem_addr},
                 {1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0});
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_nodone", {busy, done}, 2'b00);
        run_check("restart", 8'd0, 8'd3, 1'b0, 8'd0, 1'b0, 13, 0, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
